dmem_responder: RTL and testbench

Memory-side responder for the pipelined RISC-V core's load/store port. It accepts one data-memory request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then performs the byte/half/word access against an internal word-organised RAM and returns a response: load data with sign/zero extension, or a store acknowledge. It sits between the core's memory stage and on-chip storage, replacing the single-cycle data memory so the hazard unit's stall path is exercised by real memory latency.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane_align.sv | 78 +++++++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory responder
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - load extraction/extension, store byte merge and alignment check
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  f3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] ram_word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o,
   output logic        err_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   always_comb begin
      ld_byte = 8'h00;
      case (addr_lo_i)
         2'd0:    ld_byte = ram_word_i[7:0];
         2'd1:    ld_byte = ram_word_i[15:8];
         2'd2:    ld_byte = ram_word_i[23:16];
         default: ld_byte = ram_word_i[31:24];
      endcase
      ld_half = addr_lo_i[1] ? ram_word_i[31:16] : ram_word_i[15:0];
   end

   // Illegal funct3 and misalignment share one flag; the top adds the range check.
   always_comb begin
      err_o = 1'b1;
      case (f3_i)
         F3_B:  err_o = 1'b0;
         F3_H:  err_o = addr_lo_i[0];
         F3_W:  err_o = (addr_lo_i != 2'b00);
         F3_BU: err_o = we_i;
         F3_HU: err_o = we_i | addr_lo_i[0];
         default: err_o = 1'b1;
      endcase
   end

   always_comb begin
      ld_ext = 32'h0;
      case (f3_i)
         F3_B:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_BU: ld_ext = {24'h0, ld_byte};
         F3_H:  ld_ext = {{16{ld_half[15]}}, ld_half};
         F3_HU: ld_ext = {16'h0, ld_half};
         F3_W:  ld_ext = ram_word_i;
         default: ld_ext = 32'h0;
      endcase
      load_data_o = err_o ? 32'h0 : ld_ext;
   end

   always_comb begin
      store_word_o = ram_word_i;
      case (f3_i)
         F3_B: begin
            for (int i = 0; i < 4; i++) begin
               if (addr_lo_i == 2'(i)) begin
                  store_word_o[8*i +: 8] = wdata_i[7:0];
               end
            end
         end
         F3_H: begin
            if (addr_lo_i[1]) begin
               store_word_o[31:16] = wdata_i[15:0];
            end else begin
               store_word_o[15:0] = wdata_i[15:0];
            end
         end
         F3_W:    store_word_o = wdata_i;
         default: store_word_o = ram_word_i;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - request FSM, wait-state counter and word RAM for the core's load/store port
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [2:0]  req_f3_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic             we_q, we_d;
   logic [2:0]       f3_q, f3_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          exec;
   logic [31:0]   acc_addr;
   logic          acc_we;
   logic [2:0]    acc_f3;
   logic [31:0]   acc_wdata;
   logic [AW-1:0] acc_idx;
   logic          acc_oor;
   logic          acc_err;
   logic          align_err;
   logic [31:0]   ram_word;
   logic [31:0]   load_data;
   logic [31:0]   store_word;
   logic          ram_we;

   // With zero wait states the access runs on the accept edge, so it must see the live request.
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_addr  = req_addr_i;
         acc_we    = req_we_i;
         acc_f3    = req_f3_i;
         acc_wdata = req_wdata_i;
      end else begin
         acc_addr  = addr_q;
         acc_we    = we_q;
         acc_f3    = f3_q;
         acc_wdata = wdata_q;
      end
   end

   assign acc_idx  = acc_addr[AW+1:2];
   assign acc_oor  = ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS);
   assign acc_err  = align_err | acc_oor;
   assign ram_word = mem_q[acc_idx];

   dmem_lane_align u_align (
      .we_i         (acc_we),
      .f3_i         (acc_f3),
      .addr_lo_i    (acc_addr[1:0]),
      .ram_word_i   (ram_word),
      .wdata_i      (acc_wdata),
      .load_data_o  (load_data),
      .store_word_o (store_word),
      .err_o        (align_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      f3_d    = f3_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      exec    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && req_ready_q) begin
               addr_d  = req_addr_i;
               we_d    = req_we_i;
               f3_d    = req_f3_i;
               wdata_d = req_wdata_i;
               if (LATENCY == 0) begin
                  exec    = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = LAT;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               exec    = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (exec) begin
         err_d   = acc_err;
         rdata_d = (acc_err || acc_we) ? 32'h0 : load_data;
      end
   end

   assign req_ready_d = (state_d == ST_IDLE);
   assign rsp_valid_d = (state_d == ST_RESP);
   assign ram_we      = exec && acc_we && !acc_err && rst_ni;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         f3_q        <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         mem_q[acc_idx] <= store_word;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed checks of dmem_responder at LATENCY 2 and LATENCY 0
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [2:0]  req_f3;
   logic [31:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata [2];
   logic [1:0]  rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_addr_i(req_addr), .req_we_i(req_we), .req_f3_i(req_f3), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_addr_i(req_addr), .req_we_i(req_we), .req_f3_i(req_f3), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with the target instance idle.
   task automatic access(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
      req_we       = we;
      req_f3       = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid[d] = 1'b1;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      lat = 1;
      while (!rsp_valid[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata     = rsp_rdata[d];
      err       = rsp_err[d];
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      req_addr  = '0;
      req_we    = 1'b0;
      req_f3    = '0;
      req_wdata = '0;
      rst_ni    = 1'b1;
      #1 rst_ni = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rdata",     rsp_rdata[0],      32'd0);
      chk("rst_err",       32'(rsp_err[0]),   32'd0);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("sw_lat", 32'(lat), 32'd3);
      chk("sw_err", 32'(er), 32'd0);
      chk("sw_rdata", rd, 32'd0);
      access(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      chk("lw_lat", 32'(lat), 32'd3);
      chk("lw_data", rd, 32'hDEADBEEF);
      chk("lw_err", 32'(er), 32'd0);

      access(0, 1'b1, 3'b000, 32'h13, 32'h80, rd, er, lat);
      chk("sb_err", 32'(er), 32'd0);
      access(0, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
      chk("lb_data", rd, 32'hFFFFFF80);
      access(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
      chk("lbu_data", rd, 32'h00000080);
      access(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      chk("lw_merged", rd, 32'h80ADBEEF);
      access(0, 1'b0, 3'b101, 32'h12, 32'h0, rd, er, lat);
      chk("lhu_data", rd, 32'h000080AD);
      access(0, 1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
      chk("lh_data", rd, 32'hFFFF80AD);

      access(0, 1'b0, 3'b001, 32'h11, 32'h0, rd, er, lat);
      chk("lh_mis_err", 32'(er), 32'd1);
      chk("lh_mis_rdata", rd, 32'd0);
      access(0, 1'b1, 3'b010, 32'h12, 32'h1, rd, er, lat);
      chk("sw_mis_err", 32'(er), 32'd1);
      access(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      chk("lw_after_mis", rd, 32'h80ADBEEF);
      access(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
      chk("f3_011_err", 32'(er), 32'd1);
      chk("f3_011_rdata", rd, 32'd0);
      access(0, 1'b1, 3'b100, 32'h10, 32'h0, rd, er, lat);
      chk("st_f3_100_err", 32'(er), 32'd1);

      // Backpressure: response must hold while extra requests are offered
      req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h10;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      lat = 1;
      while (!rsp_valid[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd3);
      req_addr = 32'h13; req_f3 = 3'b000;
      for (int i = 0; i < 5; i++) begin
         req_valid[0] = (i % 2 == 0);
         @(posedge clk); #1;
         chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
         chk("bp_rdata", rsp_rdata[0], 32'h80ADBEEF);
         chk("bp_ready", 32'(req_ready[0]), 32'd0);
      end
      req_valid[0] = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
      end
      chk("bp_no_extra", 32'(rsp_valid[0]), 32'd0);
      chk("bp_idle", 32'(req_ready[0]), 32'd1);

      // Reset during WAIT of a store
      access(0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat);
      access(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      chk("pre_rst_lw", rd, 32'hCAFEF00D);
      req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("wait_ready", 32'(req_ready[0]), 32'd0);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(req_ready[0]), 32'd1);
      chk("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
      chk("mid_rst_rdata", rsp_rdata[0], 32'd0);
      chk("mid_rst_err", 32'(rsp_err[0]), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;
      access(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      chk("lost_store", rd, 32'hCAFEF00D);

      access(0, 1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
      chk("oor_err", 32'(er), 32'd1);
      chk("oor_rdata", rd, 32'd0);
      access(0, 1'b0, 3'b010, 32'hFFC, 32'h0, rd, er, lat);
      chk("last_word_err", 32'(er), 32'd0);

      access(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("l0_sw_lat", 32'(lat), 32'd1);
      access(1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      chk("l0_lw_lat", 32'(lat), 32'd1);
      chk("l0_lw_data", rd, 32'hDEADBEEF);
      access(1, 1'b1, 3'b001, 32'h12, 32'h1234, rd, er, lat);
      access(1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      chk("l0_sh_merge", rd, 32'h1234BEEF);
      access(1, 1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
      chk("l0_lh_data", rd, 32'h00001234);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
